// File: rtl/arrow_input_if.sv
// Bundle of the arrow-button inputs, the step pulse and the conditioned direction/seed outputs.
// The slave modport is the conditioner; the master modport is the board/game side that drives it.
interface arrow_input_if;
  logic       arrow_up;
  logic       arrow_down;
  logic       arrow_left;
  logic       arrow_right;
  logic       step;
  logic [1:0] dir;
  logic [1:0] dir_committed;
  logic       press;
  logic       reject;
  logic [7:0] seed;

  modport slave (
    input  arrow_up, arrow_down, arrow_left, arrow_right, step,
    output dir, dir_committed, press, reject, seed
  );

  modport master (
    output arrow_up, arrow_down, arrow_left, arrow_right, step,
    input  dir, dir_committed, press, reject, seed
  );
endinterface

// File: rtl/arrow_input.sv
// Arrow-button conditioner: sync, debounce, priority/reverse rejection, commit on step, entropy seed.
// Define ARROW_QUEUE_EN to buffer up to two pending turns between steps.
module arrow_input #(
  parameter int         DEBOUNCE_CYCLES = 100000,
  parameter int         CNT_W           = 17,
  parameter logic [3:0] ACTIVE_LOW      = 4'b0011,
  parameter logic [7:0] SEED_INIT       = 8'hEA
) (
  input  logic        clk,
  input  logic        reset,
  arrow_input_if.slave bus
);

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       pressed;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       rise;
  logic             any_event;
  logic [1:0]       req;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       comm_q, comm_d;
  logic             press_q, press_d;
  logic             reject_q, reject_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       seed_q, seed_d;
  logic [7:0]       seed_mix;

  // Bit index doubles as the direction code: 0 up, 1 down, 2 left, 3 right.
  assign raw     = {bus.arrow_right, bus.arrow_left, bus.arrow_down, bus.arrow_up};
  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Events come from the next stable value so press/reject line up with the stable change.
  assign rise      = stable_d & ~stable_q;
  assign any_event = |rise;

  always_comb begin
    req = 2'd3;
    if (rise[0])      req = 2'd0;
    else if (rise[1]) req = 2'd1;
    else if (rise[2]) req = 2'd2;
  end

`ifdef ARROW_QUEUE_EN
  logic [1:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0] qcnt_q, qcnt_d;
  logic [1:0] ref_dir;

  always_comb begin
    q0_d     = q0_q;
    q1_d     = q1_q;
    qcnt_d   = qcnt_q;
    comm_d   = comm_q;
    press_d  = 1'b0;
    reject_d = 1'b0;
    if (bus.step && (qcnt_q != 2'd0)) begin
      comm_d = q0_q;
      q0_d   = q1_q;
      qcnt_d = qcnt_q - 2'd1;
    end
    // Pop is applied before the push, so the check sees the post-pop tail.
    ref_dir = (qcnt_d == 2'd0) ? comm_d : ((qcnt_d == 2'd1) ? q0_d : q1_d);
    if (any_event) begin
      if ((qcnt_d == 2'd2) || (req == (ref_dir ^ 2'd1))) begin
        reject_d = 1'b1;
      end else begin
        if (qcnt_d == 2'd0) q0_d = req;
        else                q1_d = req;
        qcnt_d  = qcnt_d + 2'd1;
        press_d = 1'b1;
      end
    end
    dir_d = (qcnt_d != 2'd0) ? q0_d : comm_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0_q   <= 2'd0;
      q1_q   <= 2'd0;
      qcnt_q <= 2'd0;
    end else begin
      q0_q   <= q0_d;
      q1_q   <= q1_d;
      qcnt_q <= qcnt_d;
    end
  end
`else
  always_comb begin
    dir_d    = dir_q;
    comm_d   = bus.step ? dir_q : comm_q;
    press_d  = 1'b0;
    reject_d = 1'b0;
    if (any_event) begin
      if (req == (comm_q ^ 2'd1)) begin
        reject_d = 1'b1;
      end else begin
        dir_d   = req;
        press_d = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    seed_mix = seed_q ^ lfsr_q;
    seed_d   = seed_q;
    if (any_event) begin
      seed_d = (seed_mix == 8'h00) ? SEED_INIT : seed_mix;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      dir_q    <= 2'd0;
      comm_q   <= 2'd0;
      press_q  <= 1'b0;
      reject_q <= 1'b0;
      lfsr_q   <= SEED_INIT;
      seed_q   <= SEED_INIT;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      dir_q    <= dir_d;
      comm_q   <= comm_d;
      press_q  <= press_d;
      reject_q <= reject_d;
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
    end
  end

  assign bus.dir           = dir_q;
  assign bus.dir_committed = comm_q;
  assign bus.press         = press_q;
  assign bus.reject        = reject_q;
  assign bus.seed          = seed_q;

endmodule

// File: tb/tb_arrow_input.sv
// Directed bench for arrow_input with a short debounce window; table of level/step vectors
// plus hand-written sequences for latency, step/press coincidence and contact bounce.
module tb_arrow_input;
  localparam int DEB = 16;
  localparam int H   = DEB + 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  arrow_input_if bus ();

  arrow_input #(.DEBOUNCE_CYCLES(DEB), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up, down, left, right, step;
    int         hold;
    logic [1:0] e_dir, e_comm;
    int         e_press, e_reject;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   np, nr;

  // Reference LFSR / seed built from the polynomial and the fold-to-init rule.
  logic [7:0] m_lfsr, m_lfsr_prev, m_seed, mix;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr      <= 8'hEA;
      m_lfsr_prev <= 8'hEA;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_seed = 8'hEA;
    end else if (bus.press || bus.reject) begin
      mix    = m_seed ^ m_lfsr_prev;
      m_seed = (mix == 8'h00) ? 8'hEA : mix;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_levels(input logic u, input logic d, input logic l, input logic r);
    bus.arrow_up    = u;
    bus.arrow_down  = d;
    bus.arrow_left  = l;
    bus.arrow_right = r;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.step = 1'b0;
      if (bus.press)  np++;
      if (bus.reject) nr++;
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    np = 0;
    nr = 0;
    set_levels(v.up, v.down, v.left, v.right);
    bus.step = v.step;
    run(v.hold);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_dir", idx), int'(bus.dir), int'(v.e_dir));
    chk($sformatf("v%0d_comm", idx), int'(bus.dir_committed), int'(v.e_comm));
    chk($sformatf("v%0d_press", idx), np, v.e_press);
    chk($sformatf("v%0d_reject", idx), nr, v.e_reject);
    chk($sformatf("v%0d_seed", idx), int'(bus.seed), int'(m_seed));
  endtask

  initial begin
    int lat;
    logic [7:0] seed_before;

`ifdef ARROW_QUEUE_EN
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, H, 2'd2, 2'd0, 1, 0}); // left accepted
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, H, 2'd2, 2'd0, 0, 1}); // right reverses left
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 1, 0}); // down queued
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 0, 1}); // queue full
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 2'd1, 2'd2, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 2'd1, 2'd1, 0, 0});
`else
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd3, 2'd0, 0, 0}); // release gives nothing
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 2'd3, 2'd3, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd0, 2'd3, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, H, 2'd0, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, H, 2'd0, 2'd0, 0, 1}); // down reverses up
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd0, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, H, 2'd2, 2'd0, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd2, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, H, 2'd3, 2'd0, 1, 0}); // overwrites pending left
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, H, 2'd3, 2'd3, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, H, 2'd3, 2'd3, 0, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd3, 2'd3, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, H, 2'd0, 2'd3, 1, 0}); // up beats left
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, H, 2'd0, 2'd0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, H, 2'd3, 2'd0, 1, 0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, H, 2'd3, 2'd0, 0, 0});
`endif

    set_levels(1'b1, 1'b1, 1'b0, 1'b0);
    bus.step = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_dir", int'(bus.dir), 0);
    chk("rst_comm", int'(bus.dir_committed), 0);
    chk("rst_press", int'(bus.press), 0);
    chk("rst_reject", int'(bus.reject), 0);
    chk("rst_seed", int'(bus.seed), 8'hEA);

`ifndef ARROW_QUEUE_EN
    // Clean right press: accepted exactly 2+DEB edges after the input edge.
    bus.arrow_right = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.press) begin
        lat = k;
        break;
      end
    end
    chk("right_latency", lat, 2 + DEB);
    chk("right_dir", int'(bus.dir), 3);
    np = 0;
    nr = 0;
    run(5);
    chk("right_single_pulse", np, 0);
    @(negedge clk);
    #1;
    chk("right_seed_changed", int'(bus.seed != 8'hEA), 1);
    chk("right_seed", int'(bus.seed), int'(m_seed));
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifndef ARROW_QUEUE_EN
    // Up press lands on the same edge as step: checked against old committed (0), step commits old dir (3).
    np = 0;
    nr = 0;
    bus.arrow_up = 1'b0;
    run(1 + DEB);
    chk("coinc_early_press", np, 0);
    bus.step = 1'b1;
    run(1);
    chk("coinc_press", np, 1);
    chk("coinc_reject", nr, 0);
    chk("coinc_dir", int'(bus.dir), 0);
    chk("coinc_comm", int'(bus.dir_committed), 3);
    bus.arrow_up = 1'b1;
    run(H);
    bus.step = 1'b1;
    run(2);
    chk("coinc_next_comm", int'(bus.dir_committed), 0);

    // Contact bounce shorter than the window, then a solid hold.
    np = 0;
    nr = 0;
    seed_before = bus.seed;
    for (int b = 0; b < 4; b++) begin
      bus.arrow_left = 1'b1;
      run(DEB / 2);
      bus.arrow_left = 1'b0;
      run(10);
    end
    chk("bounce_no_press", np, 0);
    chk("bounce_seed_held", int'(bus.seed), int'(seed_before));
    bus.arrow_left = 1'b1;
    run(H);
    chk("bounce_press", np, 1);
    chk("bounce_reject", nr, 0);
    chk("bounce_dir", int'(bus.dir), 2);
    @(negedge clk);
    #1;
    chk("bounce_seed", int'(bus.seed), int'(m_seed));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
